// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used both to take absolute values of
// signed operands and to restore the sign of results.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Optional MULDIV_FAST_MUL_EN: single-pass combinational multiply (IDLE->FIX).
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one shift-add / restoring-subtract iteration per edge
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    if (ITER != 32) begin : g_bad_iter
        $error("muldiv_unit: ITER must equal the operand width of 32");
    end

    md_state_t   state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic [31:0] a_raw;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        b_zero;

    muldiv_op_t  op_in;
    logic        signed_op;
    logic        div_in;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign op_in     = muldiv_op_t'(op);
    assign signed_op = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign div_in    = (op_in == MD_DIV) || (op_in == MD_DIVU);

    muldiv_signfix #(.W(32)) u_abs_a (
        .value(operand_a), .neg(signed_op & operand_a[31]), .result(abs_a)
    );
    muldiv_signfix #(.W(32)) u_abs_b (
        .value(operand_b), .neg(signed_op & operand_b[31]), .result(abs_b)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [32:0] add_sum;
    logic [63:0] mul_next;
    assign add_sum  = {1'b0, acc[63:32]} + {1'b0, mcand};
    assign mul_next = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [63:0] div_next;
    assign shifted  = {acc[63:32], acc[31]};
    assign diff     = shifted - {1'b0, mcand};
    assign div_next = diff[32] ? {shifted[31:0], acc[30:0], 1'b0}
                               : {diff[31:0],    acc[30:0], 1'b1};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    muldiv_signfix #(.W(64)) u_fix_prod (
        .value(acc), .neg(neg_res), .result(prod_fix)
    );
    muldiv_signfix #(.W(32)) u_fix_quot (
        .value(acc[31:0]), .neg(neg_res), .result(quot_fix)
    );
    muldiv_signfix #(.W(32)) u_fix_rem (
        .value(acc[63:32]), .neg(neg_rem), .result(rem_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            a_raw       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            b_zero      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_wr) hi_out <= wr_data;
                    if (lo_wr) lo_out <= wr_data;
                    if (start) begin
                        is_div      <= div_in;
                        a_raw       <= operand_a;
                        b_zero      <= (operand_b == 32'd0);
                        neg_res     <= signed_op & (operand_a[31] ^ operand_b[31]);
                        neg_rem     <= signed_op & operand_a[31];
                        mcand       <= div_in ? abs_b : abs_a;
                        acc         <= {32'd0, div_in ? abs_a : abs_b};
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                        if (!div_in) begin
                            acc   <= {32'd0, abs_a} * {32'd0, abs_b};
                            state <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi_out <= prod_fix[63:32];
                        lo_out <= prod_fix[31:0];
                    end else if (b_zero) begin
                        hi_out      <= a_raw;
                        lo_out      <= DIV0_LO;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi_out <= rem_fix;
                        lo_out <= quot_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus multi-cycle corner sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_total = 0;
    int n_pass  = 0;

    localparam int LAT_ITER = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issues one op at the current negedge and follows it to done.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz,
                          input int exp_lat, input int glitch_at);
        int n = 0;
        int busy_cnt = 0;
        logic got = 1'b0;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
            start = (n == glitch_at);
            if (n == glitch_at) begin
                op = 2'b01; operand_a = 32'd3; operand_b = 32'd3;
            end
        end
        check({name, " done"}, 32'(got), 32'd1);
        check({name, " latency"}, busy_cnt, exp_lat);
        check({name, " busy@done"}, 32'(busy), 32'd0);
        check({name, " hi"}, hi_out, exp_hi);
        check({name, " lo"}, lo_out, exp_lo);
        check({name, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    endtask

    initial begin
        int lat;
        logic seen;
        logic [31:0] lo_before;

        vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[11] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        check("reset hi", hi_out, 32'd0);
        check("reset lo", lo_out, 32'd0);

        for (int i = 0; i < 12; i++) begin
            lat = vecs[i].op[1] ? LAT_ITER : LAT_MUL;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz, lat, 0);
            @(negedge clk);
            check($sformatf("vec%0d done one-shot", i), 32'(done), 32'd0);
        end

        // start pulsed mid-divide with changed op/operands must be ignored
        run_op("glitch", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_ITER, 10);

        // back-to-back: second start lands in the done cycle
        run_op("b2b first", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_ITER, 0);
        run_op("b2b second", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_ITER, 0);
        @(negedge clk);

        // reset in cycle 15 of a MULT aborts it
        start = 1'b1; op = 2'b00; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", hi_out, 32'd0);
        check("abort lo", lo_out, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort no done", 32'(seen), 32'd0);

        // MTHI in IDLE
        hi_wr = 1'b1; wr_data = 32'h12345678;
        @(negedge clk);
        hi_wr = 1'b0;
        check("mthi idle", hi_out, 32'h12345678);

        // MTLO while busy is ignored
        start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lo_before = lo_out;
        repeat (4) @(negedge clk);
        lo_wr = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        lo_wr = 1'b0;
        check("mtlo busy lo", lo_out, lo_before);
        check("mtlo busy hi", hi_out, 32'h12345678);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("mtlo busy done", 32'(seen), 32'd1);
        check("mtlo busy result lo", lo_out, 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
